grf_mp_sb: RTL

- Parametrised general register file for the pipelined MIPS core; next generation of the two-read, one-write GRF.
- Provides NUM_READ combinational read ports with write-to-read bypass and one synchronous write port.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight writers.
- Sits between decode (reads, issue) and writeback (write port).

---
 rtl/grf_mp_sb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/grf_mp_sb.sv
// grf_mp_sb: general register file for the pipelined MIPS core.
//
// NUM_READ combinational read ports with write-to-read bypass, one
// synchronous write port, and a per-register pending-write scoreboard
// that lets decode detect RAW hazards against in-flight writers.
//
// Optional feature macro: GRF_TRACE_EN
//   defined     -> every committed write prints one trace line with its PC
//   not defined -> no trace output, WPC is ignored
//
// Issue handshake (IssueValid / IssueReady):
//   An issue is accepted on a rising Clock edge exactly when IssueValid and
//   IssueReady are both high. IssueReady is combinational from IssueAddr and
//   the scoreboard only; it never depends on IssueValid. When IssueValid is
//   high and IssueReady is low nothing changes, and decode holds the same
//   IssueAddr and retries. Issues to register 0 are always accepted and have
//   no effect.
module grf_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int CNT_W    = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         RegWrite,
    input  logic [ADDR_W-1:0]            WA,
    input  logic [DATA_W-1:0]            WD,
    input  logic [31:0]                  WPC,
    input  logic [NUM_READ*ADDR_W-1:0]   RA,
    output logic [NUM_READ*DATA_W-1:0]   RD,
    output logic [NUM_READ-1:0]          RBusy,
    input  logic                         IssueValid,
    input  logic [ADDR_W-1:0]            IssueAddr,
    output logic                         IssueReady
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Architectural register storage and pending-writer counters.
    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  cnt  [DEPTH];

    // A write that actually lands (register 0 is never written).
    logic wr_fire;
    // An issue that is accepted and targets a real register.
    logic issue_fire;
    // Per-register increment / decrement requests for this cycle.
    logic [DEPTH-1:0] inc_vec;
    logic [DEPTH-1:0] dec_vec;

    // Qualify write and issue; IssueReady drops only on a saturated counter.
    always_comb begin
        wr_fire    = RegWrite && (WA != '0);
        IssueReady = 1'b1;
        if (!Reset && (IssueAddr != '0) && (cnt[IssueAddr] == CNT_MAX)) begin
            IssueReady = 1'b0;
        end
        issue_fire = IssueValid && IssueReady && (IssueAddr != '0) && !Reset;
    end

    // Decode which counter moves; a write to an unscoreboarded register
    // (count already 0) leaves its counter alone.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_fire) begin
            inc_vec[IssueAddr] = 1'b1;
        end
        if (wr_fire && (cnt[WA] != '0)) begin
            dec_vec[WA] = 1'b1;
        end
    end

    // Register array: cleared asynchronously, written on the rising edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_fire) begin
            regs[WA] <= WD;
        end
    end

    // Scoreboard counters: +1 on accepted issue, -1 on resolving write,
    // unchanged when both hit the same register in the same cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // Read ports: each port is independent and identical.
    logic [DATA_W-1:0] rd_port   [NUM_READ];
    logic              busy_port [NUM_READ];

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic [CNT_W-1:0]  cur_cnt;
        logic [CNT_W-1:0]  eff_cnt;

        // Bypass the in-flight write, then report whether a writer is still
        // outstanding once that write has been accounted for.
        always_comb begin
            ra           = RA[k*ADDR_W +: ADDR_W];
            hit          = wr_fire && (WA == ra);
            cur_cnt      = cnt[ra];
            eff_cnt      = cur_cnt;
            rd_port[k]   = '0;
            busy_port[k] = 1'b0;
            if (hit && (cur_cnt != '0)) begin
                eff_cnt = cur_cnt - 1'b1;
            end
            if (!Reset && (ra != '0)) begin
                rd_port[k]   = hit ? WD : regs[ra];
                busy_port[k] = (eff_cnt != '0);
            end
        end

        assign RD[k*DATA_W +: DATA_W] = rd_port[k];
        assign RBusy[k]               = busy_port[k];
    end

`ifdef GRF_TRACE_EN
    // Trace every committed write with the PC of the writing instruction.
    always @(posedge Clock) begin
        if (!Reset && wr_fire) begin
            $display("%d@%h: $%d <= %h", $time, WPC, WA, WD);
        end
    end
`else
    // WPC only feeds the trace; fold it into a deliberately unused net.
    logic unused_wpc;
    assign unused_wpc = ^WPC;
`endif

endmodule
